// File: rtl/even_issue_sched.sv
// Even-pipe issue scheduler: checks RAW/WAW hazards and result-bus slots against
// a shifting reservation table, then strobes the selected even unit.
module even_issue_sched #(
  parameter int LAT_FX2  = 2,
  parameter int LAT_BYTE = 2,
  parameter int LAT_FX3  = 4,
  parameter int LAT_SP   = 6,
  parameter int LAT_FPI  = 7,
  parameter int MAX_LAT  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [0:31] inst_even,
  input  logic [0:2]  unit_code,
  input  logic        uses_rb,
  input  logic        op_11_in,
  input  logic        flush,
  output logic        inst_ready,
  output logic        fx2_unit_sel,
  output logic        byte_unit_sel,
  output logic        fx3_unit_sel,
  output logic        sp_unit_sel,
  output logic        fpi_unit_sel,
  output logic [0:31] inst_out,
  output logic        op_11_even,
  output logic        unit_reset_even,
  output logic        wb_pred_valid,
  output logic [0:6]  wb_pred_rt,
  output logic [0:15] issue_cnt,
  output logic [0:15] stall_cnt
);

  localparam int LW = $clog2(MAX_LAT + 1);

  // Handshake: an instruction transfers in any cycle where inst_valid and
  // inst_ready are both high; while inst_ready is low decode holds it stable.

  logic [MAX_LAT:0] tbl_v;
  logic [0:6]       tbl_rt [0:MAX_LAT];

  logic [0:6]    rb_f, ra_f, rt_f;
  logic [LW-1:0] lat;
  logic [LW-1:0] lat_m1;
  logic          has_unit;
  logic          conflict;
  logic          hazard;
  logic          hit;
  logic          issue;

  assign rb_f = inst_even[11:17];
  assign ra_f = inst_even[18:24];
  assign rt_f = inst_even[25:31];

  always_comb begin
    lat      = '0;
    has_unit = 1'b0;
    case (unit_code)
      3'd1: begin lat = LAT_FX2[LW-1:0];  has_unit = 1'b1; end
      3'd2: begin lat = LAT_BYTE[LW-1:0]; has_unit = 1'b1; end
      3'd3: begin lat = LAT_FX3[LW-1:0];  has_unit = 1'b1; end
      3'd4: begin lat = LAT_SP[LW-1:0];   has_unit = 1'b1; end
      3'd5: begin lat = LAT_FPI[LW-1:0];  has_unit = 1'b1; end
      default: begin lat = '0; has_unit = 1'b0; end
    endcase
  end

  assign lat_m1 = lat - 1'b1;

  // Entry 0 is still checked: its writeback lands this very cycle.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (tbl_v[k] && ((tbl_rt[k] == ra_f) ||
                       (uses_rb && (tbl_rt[k] == rb_f)) ||
                       (tbl_rt[k] == rt_f)))
        hit = 1'b1;
    end
  end

  assign conflict = has_unit & tbl_v[lat];
  assign hazard   = has_unit & hit;

  assign inst_ready = inst_valid & ~reset & ~flush & ~unit_reset_even &
                      ~conflict & ~hazard;
  assign issue      = inst_ready & has_unit;

  assign fx2_unit_sel  = issue & (unit_code == 3'd1);
  assign byte_unit_sel = issue & (unit_code == 3'd2);
  assign fx3_unit_sel  = issue & (unit_code == 3'd3);
  assign sp_unit_sel   = issue & (unit_code == 3'd4);
  assign fpi_unit_sel  = issue & (unit_code == 3'd5);

  assign inst_out      = inst_even;
  assign op_11_even    = op_11_in;
  assign wb_pred_valid = tbl_v[0];
  assign wb_pred_rt    = tbl_rt[0];

  // Shift toward entry 0; a new issue lands at L-1 so it reaches entry 0 at T+L.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tbl_v <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++) begin
        tbl_v[k]  <= tbl_v[k+1];
        tbl_rt[k] <= tbl_rt[k+1];
      end
      tbl_v[MAX_LAT] <= 1'b0;
      if (issue) begin
        tbl_v[lat_m1]  <= 1'b1;
        tbl_rt[lat_m1] <= rt_f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unit_reset_even <= 1'b0;
      issue_cnt       <= '0;
      stall_cnt       <= '0;
    end else begin
      unit_reset_even <= flush;
      if (issue && (issue_cnt != 16'hFFFF))
        issue_cnt <= issue_cnt + 16'd1;
      if (inst_valid && !inst_ready && !flush && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
